// File: rtl/thresholding_pkg.sv
// Shared helpers for the thresholding core and its stream adapters.
package thresholding_pkg;

  // AXI-stream data width: bit count rounded up to whole bytes.
  function automatic int axis_width(int w);
    return ((w + 7) / 8) * 8;
  endfunction

  // Counter width able to hold 0..n-1; never narrower than one bit.
  function automatic int cnt_bits(int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/thresholding_out_packer.sv
// Packs K consecutive W-bit channel values into one wide AXI-stream word.
// A partial word is zero-padded and flushed at the last channel of a pixel,
// and tlast marks the word holding channel C-1.
module thresholding_out_packer
  import thresholding_pkg::*;
#(
  parameter int unsigned W = 4,
  parameter int unsigned K = 3,
  parameter int unsigned C = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  output logic                           s_axis_tready,
  input  logic                           s_axis_tvalid,
  input  logic [axis_width(W)-1:0]       s_axis_tdata,
  input  logic                           m_axis_tready,
  output logic                           m_axis_tvalid,
  output logic [axis_width(K*W)-1:0]     m_axis_tdata,
  output logic                           m_axis_tlast
);

  localparam int unsigned OW = axis_width(K * W);
  localparam int unsigned AW = K * W;
  localparam int PB = cnt_bits(K);
  localparam int CB = cnt_bits(C);
  localparam logic [PB-1:0] PosMax = PB'(K - 1);
  localparam logic [CB-1:0] ChnMax = CB'(C - 1);

  logic [AW-1:0] acc_q, acc_d;
  logic [PB-1:0] pos_q, pos_d;
  logic          pos_last_q, pos_last_d;
  logic [CB-1:0] chn_q, chn_d;
  logic          chn_last_q, chn_last_d;
  logic          ovld_q, ovld_d;
  logic [OW-1:0] odata_q, odata_d;
  logic          olast_q, olast_d;

  logic [W-1:0]  elem;
  logic [AW-1:0] word;
  logic          accept;
  logic          complete;
  logic          unused_tdata;

  // Only the low W bits carry the element; the byte padding is ignored.
  assign elem         = s_axis_tdata[W-1:0];
  assign unused_tdata = ^s_axis_tdata;

  // Stall input only while a finished word is waiting on downstream.
  assign s_axis_tready = !ovld_q || m_axis_tready;
  assign accept        = s_axis_tvalid && s_axis_tready;
  assign complete      = accept && (pos_last_q || chn_last_q);

  assign m_axis_tvalid = ovld_q;
  assign m_axis_tdata  = odata_q;
  assign m_axis_tlast  = olast_q;

  // Accumulator with the incoming element merged into slot pos; later slots zeroed.
  always_comb begin
    word = acc_q;
    for (int i = 0; i < int'(K); i++) begin
      if (PB'(i) == pos_q) begin
        word[i*W +: W] = elem;
      end else if (PB'(i) > pos_q) begin
        word[i*W +: W] = '0;
      end
    end
  end

  // Slot and channel counters with registered last flags.
  always_comb begin
    acc_d      = acc_q;
    pos_d      = pos_q;
    pos_last_d = pos_last_q;
    chn_d      = chn_q;
    chn_last_d = chn_last_q;
    if (accept) begin
      if (complete) begin
        pos_d = '0;
        acc_d = '0;
      end else begin
        pos_d = pos_q + 1'b1;
        acc_d = word;
      end
      pos_last_d = (pos_d == PosMax);
      chn_d      = chn_last_q ? '0 : chn_q + 1'b1;
      chn_last_d = (chn_d == ChnMax);
    end
  end

  // Output register: load on completion, otherwise drain on downstream ready.
  always_comb begin
    ovld_d  = ovld_q;
    odata_d = odata_q;
    olast_d = olast_q;
    if (complete) begin
      ovld_d  = 1'b1;
      odata_d = OW'(word);
      olast_d = chn_last_q;
    end else if (m_axis_tready) begin
      ovld_d = 1'b0;
    end
  end

  // State registers, synchronous reset discards any partial or pending word.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q      <= '0;
      pos_q      <= '0;
      pos_last_q <= (K == 1);
      chn_q      <= '0;
      chn_last_q <= (C == 1);
      ovld_q     <= 1'b0;
      odata_q    <= '0;
      olast_q    <= 1'b0;
    end else begin
      acc_q      <= acc_d;
      pos_q      <= pos_d;
      pos_last_q <= pos_last_d;
      chn_q      <= chn_d;
      chn_last_q <= chn_last_d;
      ovld_q     <= ovld_d;
      odata_q    <= odata_d;
      olast_q    <= olast_d;
    end
  end

endmodule

// File: tb/tb_thresholding_out_packer.sv
// Directed bench for thresholding_out_packer in three configurations.
module tb_thresholding_out_packer;

  logic clk;
  logic rst;

  // A: W=4 K=3 C=8
  logic        a_sr, a_sv, a_mr, a_mv, a_ml;
  logic [7:0]  a_sd;
  logic [15:0] a_md;
  // B: W=8 K=4 C=1
  logic        b_sr, b_sv, b_mr, b_mv, b_ml;
  logic [7:0]  b_sd;
  logic [31:0] b_md;
  // C: W=2 K=4 C=4
  logic        c_sr, c_sv, c_mr, c_mv, c_ml;
  logic [7:0]  c_sd;
  logic [7:0]  c_md;

  int checks = 0;
  int errors = 0;

  thresholding_out_packer #(.W(4), .K(3), .C(8)) u_a (
    .clk(clk), .rst(rst),
    .s_axis_tready(a_sr), .s_axis_tvalid(a_sv), .s_axis_tdata(a_sd),
    .m_axis_tready(a_mr), .m_axis_tvalid(a_mv), .m_axis_tdata(a_md), .m_axis_tlast(a_ml)
  );

  thresholding_out_packer #(.W(8), .K(4), .C(1)) u_b (
    .clk(clk), .rst(rst),
    .s_axis_tready(b_sr), .s_axis_tvalid(b_sv), .s_axis_tdata(b_sd),
    .m_axis_tready(b_mr), .m_axis_tvalid(b_mv), .m_axis_tdata(b_md), .m_axis_tlast(b_ml)
  );

  thresholding_out_packer #(.W(2), .K(4), .C(4)) u_c (
    .clk(clk), .rst(rst),
    .s_axis_tready(c_sr), .s_axis_tvalid(c_sv), .s_axis_tdata(c_sd),
    .m_axis_tready(c_mr), .m_axis_tvalid(c_mv), .m_axis_tdata(c_md), .m_axis_tlast(c_ml)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Feed channels first..last to A back-to-back and check each cycle's output.
  task automatic send_a(input int first, input int last_);
    for (int i = first; i <= last_; i++) begin
      a_sv = 1'b1;
      a_sd = {4'hF, 4'(i)};
      chk("a_sready", 32'(a_sr), 32'd1);
      @(posedge clk);
      #1;
      if (i == 3 || i == 6 || i == 8) begin
        chk("a_mvalid", 32'(a_mv), 32'd1);
        chk("a_mdata", 32'(a_md), (i == 3) ? 32'h0321 : (i == 6) ? 32'h0654 : 32'h0087);
        chk("a_mlast", 32'(a_ml), (i == 8) ? 32'd1 : 32'd0);
      end else begin
        chk("a_mvalid_idle", 32'(a_mv), 32'd0);
      end
    end
    a_sv = 1'b0;
  endtask

  logic [1:0]  c_elem;
  logic [7:0]  c_acc;
  int          c_slot;
  int          c_k;
  int          c_pops;
  logic [7:0]  c_q[$];
  logic [39:0] vpat;
  logic [39:0] rpat;

  initial begin
    rst  = 1'b1;
    a_sv = 1'b0; a_sd = '0; a_mr = 1'b1;
    b_sv = 1'b0; b_sd = '0; b_mr = 1'b1;
    c_sv = 1'b0; c_sd = '0; c_mr = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_a_mvalid", 32'(a_mv), 32'd0);
    chk("rst_a_mdata", 32'(a_md), 32'd0);
    chk("rst_a_mlast", 32'(a_ml), 32'd0);
    chk("rst_b_mvalid", 32'(b_mv), 32'd0);
    chk("rst_c_mvalid", 32'(c_mv), 32'd0);
    chk("rst_c_mdata", 32'(c_md), 32'd0);
    rst = 1'b0;

    // Two pixels back-to-back.
    send_a(1, 8);
    send_a(1, 8);

    // Backpressure after the first word of a pixel.
    send_a(1, 3);
    a_mr = 1'b0;
    a_sv = 1'b1;
    a_sd = 8'h04;
    #1;
    chk("bp_sready_low", 32'(a_sr), 32'd0);
    for (int n = 0; n < 10; n++) begin
      @(posedge clk);
      #1;
      chk("bp_mvalid", 32'(a_mv), 32'd1);
      chk("bp_mdata", 32'(a_md), 32'h0321);
      chk("bp_mlast", 32'(a_ml), 32'd0);
      chk("bp_sready", 32'(a_sr), 32'd0);
    end
    a_mr = 1'b1;
    #1;
    chk("bp_sready_rel", 32'(a_sr), 32'd1);
    send_a(4, 8);

    // Reset in the middle of a pixel discards the partial word.
    send_a(1, 2);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("mid_rst_mvalid", 32'(a_mv), 32'd0);
    chk("mid_rst_mdata", 32'(a_md), 32'd0);
    chk("mid_rst_mlast", 32'(a_ml), 32'd0);
    rst = 1'b0;
    send_a(1, 8);

    // C=1: every element is its own word with tlast.
    b_sv = 1'b1;
    b_sd = 8'hA5;
    @(posedge clk);
    #1;
    chk("b_mvalid0", 32'(b_mv), 32'd1);
    chk("b_mdata0", b_md, 32'h000000A5);
    chk("b_mlast0", 32'(b_ml), 32'd1);
    b_sd = 8'h5A;
    @(posedge clk);
    #1;
    chk("b_mvalid1", 32'(b_mv), 32'd1);
    chk("b_mdata1", b_md, 32'h0000005A);
    chk("b_mlast1", 32'(b_ml), 32'd1);
    b_sv = 1'b0;
    @(posedge clk);
    #1;
    chk("b_mvalid_idle", 32'(b_mv), 32'd0);

    // K=C=4: first 16 cycles stall-free, then irregular valid/ready.
    vpat = {24'b1011_0111_0101_1110_1101_1011, 16'hFFFF};
    rpat = {24'b1100_1111_0110_1011_1001_1110, 16'hFFFF};
    c_acc  = '0;
    c_slot = 0;
    c_k    = 0;
    c_pops = 0;
    for (int n = 0; n < 46; n++) begin
      c_elem = 2'((c_k * 3 + 1) % 4);
      c_sv   = (n < 40) ? vpat[n] : 1'b0;
      c_sd   = {6'b101010, c_elem};
      c_mr   = (n < 40) ? rpat[n] : 1'b1;
      #1;
      if (c_mv && c_mr) begin
        if (n < 16) c_pops++;
        chk("c_qnonempty", 32'(c_q.size() > 0), 32'd1);
        chk("c_mlast", 32'(c_ml), 32'd1);
        if (c_q.size() > 0) begin
          chk("c_mdata", 32'(c_md), 32'(c_q[0]));
          void'(c_q.pop_front());
        end
      end
      if (c_sv && c_sr) begin
        c_acc = c_acc | (8'(c_elem) << (2 * c_slot));
        c_slot++;
        c_k++;
        if (c_slot == 4) begin
          c_q.push_back(c_acc);
          c_acc  = '0;
          c_slot = 0;
        end
      end
      @(posedge clk);
      #1;
    end
    chk("c_rate", 32'(c_pops), 32'd3);
    chk("c_drained", 32'(c_q.size()), 32'd0);
    chk("c_mvalid_end", 32'(c_mv), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
